// File: rtl/av2_forward_transform_4x4.sv
// Encoder 4x4 forward integer transform: row butterfly on acceptance, one-cycle
// column pass (core DCT or x16 identity), then four coefficient rows out.
module av2_forward_transform_4x4 #(
    parameter int BIT_DEPTH = 10,
    parameter int COEF_W    = 16
) (
    input  logic                       clk,
    input  logic                       rst,
    input  logic                       in_valid,
    output logic                       in_ready,
    input  logic [4*(BIT_DEPTH+1)-1:0] in_row,
    input  logic                       tx_type,
    output logic                       out_valid,
    input  logic                       out_ready,
    output logic [4*COEF_W-1:0]        out_row,
    output logic                       out_last,
    output logic                       busy
);
    localparam int RES_W = BIT_DEPTH + 1;
    localparam int ROW_W = RES_W + 3;
    localparam int COL_W = RES_W + 6;
    localparam logic signed [COL_W-1:0] SAT_MAX = COL_W'((2 ** (COEF_W - 1)) - 1);
    localparam logic signed [COL_W-1:0] SAT_MIN = ~SAT_MAX;

    typedef enum logic [1:0] {
        LOAD  = 2'd0,
        XFORM = 2'd1,
        OUT   = 2'd2
    } state_t;

    state_t                  state;
    logic [1:0]              row_cnt;
    logic [1:0]              out_cnt;
    logic                    tx_id;

    logic signed [ROW_W-1:0] t_buf [4][4];
    logic signed [COEF_W-1:0] y_buf [4][4];

    logic                    row_ident;
    logic signed [ROW_W-1:0] row_x [4];
    logic signed [ROW_W-1:0] row_y [4];
    logic signed [ROW_W-1:0] rs0, rs1, rd0, rd1;

    logic signed [COL_W-1:0] col_x [4];
    logic [4*COL_W-1:0]      col_res;
    logic signed [COEF_W-1:0] y_next [4][4];

    function automatic logic signed [COEF_W-1:0] sat(input logic signed [COL_W-1:0] v);
        if (v > SAT_MAX)
            sat = SAT_MAX[COEF_W-1:0];
        else if (v < SAT_MIN)
            sat = SAT_MIN[COEF_W-1:0];
        else
            sat = v[COEF_W-1:0];
    endfunction

    function automatic logic [4*COL_W-1:0] butterfly(
        input logic signed [COL_W-1:0] x0,
        input logic signed [COL_W-1:0] x1,
        input logic signed [COL_W-1:0] x2,
        input logic signed [COL_W-1:0] x3
    );
        logic signed [COL_W-1:0] s0, s1, d0, d1;
        s0 = x0 + x3;
        s1 = x1 + x2;
        d0 = x0 - x3;
        d1 = x1 - x2;
        butterfly = {d0 - (d1 <<< 1), s0 - s1, (d0 <<< 1) + d1, s0 + s1};
    endfunction

    // Row pass on the incoming row; row 0 uses the live tx_type since it is latched on that beat.
    always_comb begin
        row_ident = (row_cnt == 2'd0) ? tx_type : tx_id;
        for (int c = 0; c < 4; c++) begin
            row_x[c] = {{(ROW_W-RES_W){in_row[c*RES_W+RES_W-1]}}, in_row[c*RES_W +: RES_W]};
        end
        rs0 = row_x[0] + row_x[3];
        rs1 = row_x[1] + row_x[2];
        rd0 = row_x[0] - row_x[3];
        rd1 = row_x[1] - row_x[2];
        for (int c = 0; c < 4; c++) begin
            row_y[c] = row_x[c];
        end
        if (!row_ident) begin
            row_y[0] = rs0 + rs1;
            row_y[1] = (rd0 <<< 1) + rd1;
            row_y[2] = rs0 - rs1;
            row_y[3] = rd0 - (rd1 <<< 1);
        end
    end

    always_comb begin
        for (int r = 0; r < 4; r++) begin
            col_x[r] = '0;
            for (int c = 0; c < 4; c++) begin
                y_next[r][c] = '0;
            end
        end
        col_res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                col_x[r] = {{(COL_W-ROW_W){t_buf[r][c][ROW_W-1]}}, t_buf[r][c]};
            end
            col_res = butterfly(col_x[0], col_x[1], col_x[2], col_x[3]);
            for (int k = 0; k < 4; k++) begin
                if (tx_id)
                    y_next[k][c] = sat(col_x[k] <<< 4);
                else
                    y_next[k][c] = sat(col_res[k*COL_W +: COL_W]);
            end
        end
    end

    always_comb begin
        out_row = '0;
        if (state == OUT) begin
            for (int c = 0; c < 4; c++) begin
                out_row[c*COEF_W +: COEF_W] = y_buf[out_cnt][c];
            end
        end
    end

    assign busy = (state != LOAD) || (row_cnt != 2'd0);

    // Block sequencer; in_ready is registered so it stays low throughout reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= LOAD;
            row_cnt   <= 2'd0;
            out_cnt   <= 2'd0;
            tx_id     <= 1'b0;
            in_ready  <= 1'b0;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            for (int r = 0; r < 4; r++) begin
                for (int c = 0; c < 4; c++) begin
                    t_buf[r][c] <= '0;
                    y_buf[r][c] <= '0;
                end
            end
        end else begin
            case (state)
                LOAD: begin
                    in_ready <= 1'b1;
                    if (in_valid && in_ready) begin
                        for (int c = 0; c < 4; c++) begin
                            t_buf[row_cnt][c] <= row_y[c];
                        end
                        if (row_cnt == 2'd0)
                            tx_id <= tx_type;
                        row_cnt <= row_cnt + 2'd1;
                        if (row_cnt == 2'd3) begin
                            state    <= XFORM;
                            in_ready <= 1'b0;
                        end
                    end
                end
                XFORM: begin
                    for (int r = 0; r < 4; r++) begin
                        for (int c = 0; c < 4; c++) begin
                            y_buf[r][c] <= y_next[r][c];
                        end
                    end
                    state     <= OUT;
                    out_valid <= 1'b1;
                    out_last  <= 1'b0;
                    out_cnt   <= 2'd0;
                end
                OUT: begin
                    if (out_ready) begin
                        out_cnt  <= out_cnt + 2'd1;
                        out_last <= (out_cnt == 2'd2);
                        if (out_cnt == 2'd3) begin
                            out_valid <= 1'b0;
                            out_last  <= 1'b0;
                            out_cnt   <= 2'd0;
                            state     <= LOAD;
                            in_ready  <= 1'b1;
                        end
                    end
                end
                default: begin
                    state     <= LOAD;
                    in_ready  <= 1'b0;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end
            endcase
        end
    end

endmodule
